// File: rtl/ins_fetcher_pkg.sv
// ins_fetcher_pkg
//   Shared types and constants for the instruction fetch stage:
//   address/instruction word types, fetch FSM state encoding and
//   the PC increment.
package ins_fetcher_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INS_W  = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INS_W-1:0]  ins_t;

    localparam addr_t ZERO_WORD = '0;
    localparam addr_t PC_STEP   = 32'd4;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } fetch_state_t;

    // Width of the cache index field for a power-of-two line count.
    function automatic int unsigned icache_index_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/ins_fetcher_icache.sv
// icache
//   Direct-mapped instruction cache with one 32-bit word per line.
//   index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
// Ports
//   clk        : clock, rising edge
//   i_rst_n    : asynchronous active-low clear of all valid bits
//   i_rd_addr  : lookup address (combinational read port)
//   o_hit      : line valid and tag match for i_rd_addr
//   o_rd_data  : data word of the indexed line
//   i_wr_en    : write strobe (synchronous)
//   i_wr_addr  : address being filled
//   i_wr_data  : word being filled
module icache
    import ins_fetcher_pkg::*;
#(
    parameter int unsigned ENTRIES = 256
) (
    input  logic  clk,
    input  logic  i_rst_n,
    input  addr_t i_rd_addr,
    output logic  o_hit,
    output ins_t  o_rd_data,
    input  logic  i_wr_en,
    input  addr_t i_wr_addr,
    input  ins_t  i_wr_data
);

    localparam int unsigned IDX_W = icache_index_w(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [ENTRIES];
    ins_t               r_data [ENTRIES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [TAG_W-1:0] w_wr_tag;

    assign w_rd_idx = i_rd_addr[IDX_W+1:2];
    assign w_rd_tag = i_rd_addr[ADDR_W-1:IDX_W+2];
    assign w_wr_idx = i_wr_addr[IDX_W+1:2];
    assign w_wr_tag = i_wr_addr[ADDR_W-1:IDX_W+2];

    assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_data = r_data[w_rd_idx];

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= i_wr_data;
        end
    end

endmodule

// File: rtl/ins_fetcher.sv
// ins_fetcher
//   Instruction fetch stage. Holds the PC, looks it up in a direct-mapped
//   icache and issues one instruction per cycle on hits. Misses request
//   the word from memory, fill the line and retry the lookup.
// Ports
//   clk, rst            : clock; asynchronous active-low reset
//   rdy                 : global enable, all state holds when low
//   stall_in            : downstream full, blocks issue and new requests
//   jump_flag, jump_pc  : PC redirect
//   flag_to_mem/addr_to_mem     : fetch request (level) and address
//   flag_from_mem/inst_from_mem : one-cycle ack with fetched word
//   flag_to_dec/inst_to_dec/pc_to_dec : registered issue pulse, word, PC
module ins_fetcher
    import ins_fetcher_pkg::*;
#(
    parameter int unsigned ICACHE_ENTRIES = 256,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_in,
    input  logic        jump_flag,
    input  logic [31:0] jump_pc,
    output logic        flag_to_mem,
    output logic [31:0] addr_to_mem,
    input  logic        flag_from_mem,
    input  logic [31:0] inst_from_mem,
    output logic        flag_to_dec,
    output logic [31:0] inst_to_dec,
    output logic [31:0] pc_to_dec
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    addr_t        r_pc;
    addr_t        w_pc_nxt;

    logic  w_flag_to_mem_nxt;
    addr_t w_addr_to_mem_nxt;
    logic  w_flag_to_dec_nxt;
    ins_t  w_inst_to_dec_nxt;
    addr_t w_pc_to_dec_nxt;

    logic  w_hit;
    ins_t  w_hit_data;
    logic  w_fill_en;

    icache #(
        .ENTRIES (ICACHE_ENTRIES)
    ) u_icache (
        .clk       (clk),
        .i_rst_n   (rst),
        .i_rd_addr (r_pc),
        .o_hit     (w_hit),
        .o_rd_data (w_hit_data),
        .i_wr_en   (w_fill_en),
        .i_wr_addr (addr_to_mem),
        .i_wr_data (inst_from_mem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            flag_to_mem <= 1'b0;
            addr_to_mem <= ZERO_WORD;
            flag_to_dec <= 1'b0;
            inst_to_dec <= ZERO_WORD;
            pc_to_dec   <= ZERO_WORD;
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            flag_to_mem <= w_flag_to_mem_nxt;
            addr_to_mem <= w_addr_to_mem_nxt;
            flag_to_dec <= w_flag_to_dec_nxt;
            inst_to_dec <= w_inst_to_dec_nxt;
            pc_to_dec   <= w_pc_to_dec_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_flag_to_mem_nxt = flag_to_mem;
        w_addr_to_mem_nxt = addr_to_mem;
        w_flag_to_dec_nxt = 1'b0;
        w_inst_to_dec_nxt = inst_to_dec;
        w_pc_to_dec_nxt   = pc_to_dec;
        w_fill_en         = 1'b0;

        case (r_state)
            IDLE: begin
                // A redirect suppresses both issue and miss request.
                if (jump_flag) begin
                    w_pc_nxt = jump_pc;
                end else if (!stall_in) begin
                    if (w_hit) begin
                        w_flag_to_dec_nxt = 1'b1;
                        w_inst_to_dec_nxt = w_hit_data;
                        w_pc_to_dec_nxt   = r_pc;
                        w_pc_nxt          = r_pc + PC_STEP;
                    end else begin
                        w_flag_to_mem_nxt = 1'b1;
                        w_addr_to_mem_nxt = r_pc;
                        w_state_nxt       = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                // The outstanding request is never cancelled: a redirect
                // only retargets the PC, and the ack still fills its line.
                if (jump_flag) begin
                    w_pc_nxt = jump_pc;
                end
                if (flag_from_mem) begin
                    w_fill_en         = rdy;
                    w_flag_to_mem_nxt = 1'b0;
                    w_state_nxt       = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ins_fetcher.sv
module tb_ins_fetcher;

    localparam int LAT = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } issue_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        stall_in;
    logic        jf_stim;
    logic [31:0] jpc_stim;
    logic        ack_jump;
    logic [31:0] ack_jpc;
    logic        jump_flag;
    logic [31:0] jump_pc;
    logic        flag_to_mem;
    logic [31:0] addr_to_mem;
    logic        ack;
    logic [31:0] ack_data;
    logic        flag_to_dec;
    logic [31:0] inst_to_dec;
    logic [31:0] pc_to_dec;

    logic        last_rdy = 1'b1;
    logic        jump_on_ack;
    logic [31:0] jump_on_ack_pc;
    int          stray_cnt;

    int vectors    = 0;
    int miscompares = 0;

    issue_t      issue_q[$];
    logic [31:0] req_q[$];

    assign jump_flag = jf_stim | ack_jump;
    assign jump_pc   = ack_jump ? ack_jpc : jpc_stim;

    ins_fetcher #(
        .ICACHE_ENTRIES (256),
        .RESET_PC       (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .stall_in      (stall_in),
        .jump_flag     (jump_flag),
        .jump_pc       (jump_pc),
        .flag_to_mem   (flag_to_mem),
        .addr_to_mem   (addr_to_mem),
        .flag_from_mem (ack),
        .inst_from_mem (ack_data),
        .flag_to_dec   (flag_to_dec),
        .inst_to_dec   (inst_to_dec),
        .pc_to_dec     (pc_to_dec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) last_rdy <= rdy;

    // Backing memory contents: word at address a is {a[23:0], 8'h13}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push_issue(input logic [31:0] pc, input logic [31:0] inst);
        issue_t e;
        e.pc   = pc;
        e.inst = inst;
        issue_q.push_back(e);
    endtask

    task automatic wait_issue(input logic [31:0] pc, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(flag_to_dec && last_rdy && pc_to_dec == pc) && n < 200);
        vectors++;
        if (!(flag_to_dec && pc_to_dec == pc)) begin
            miscompares++;
            $display("FAIL %s: no issue of pc %h within %0d cycles", name, pc, n);
        end
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!flag_to_mem && n < 200);
        vectors++;
        if (!flag_to_mem) begin
            miscompares++;
            $display("FAIL %s: no memory request within %0d cycles", name, n);
        end
    endtask

    // Memory responder: ack LAT cycles after the request becomes visible,
    // optionally with a redirect in the very same cycle.
    initial begin : responder
        int cnt;
        int stray_seen;
        ack = 1'b0; ack_data = '0; ack_jump = 1'b0; ack_jpc = '0;
        cnt = 0; stray_seen = 0;
        forever begin
            @(negedge clk);
            ack_jump = 1'b0;
            if (ack) begin
                ack = 1'b0;
                cnt = 0;
            end else if (!rst) begin
                cnt = 0;
            end else if (stray_seen != stray_cnt) begin
                stray_seen = stray_cnt;
                ack        = 1'b1;
                ack_data   = 32'hDEADBEEF;
            end else if (flag_to_mem) begin
                cnt++;
                if (cnt == LAT + 1) begin
                    ack      = 1'b1;
                    ack_data = mem_word(addr_to_mem);
                    cnt      = 0;
                    if (jump_on_ack) begin
                        ack_jump = 1'b1;
                        ack_jpc  = jump_on_ack_pc;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: pops expectations whenever the DUT issues or
    // raises a new memory request.
    initial begin : monitor
        logic        prev_fm;
        logic [31:0] prev_addr;
        issue_t      e;
        logic [31:0] ea;
        prev_fm = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst && last_rdy) begin
                if (flag_to_dec) begin
                    if (issue_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_issue: pc_to_dec=%h inst_to_dec=%h, none expected", pc_to_dec, inst_to_dec);
                    end else begin
                        e = issue_q.pop_front();
                        check32("issue_pc", pc_to_dec, e.pc);
                        check32("issue_inst", inst_to_dec, e.inst);
                    end
                end
                if (flag_to_mem && !prev_fm) begin
                    if (req_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_request: addr_to_mem=%h, none expected", addr_to_mem);
                    end else begin
                        ea = req_q.pop_front();
                        check32("req_addr", addr_to_mem, ea);
                    end
                end else if (flag_to_mem && prev_fm) begin
                    check32("req_addr_stable", addr_to_mem, prev_addr);
                end
            end
            prev_fm   = flag_to_mem;
            prev_addr = addr_to_mem;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        rst = 1'b0; rdy = 1'b1; stall_in = 1'b1;
        jf_stim = 1'b0; jpc_stim = '0;
        jump_on_ack = 1'b0; jump_on_ack_pc = '0; stray_cnt = 0;

        repeat (3) @(negedge clk);
        check1 ("rst_flag_to_mem", flag_to_mem, 1'b0);
        check32("rst_addr_to_mem", addr_to_mem, 32'h0);
        check1 ("rst_flag_to_dec", flag_to_dec, 1'b0);
        check32("rst_inst_to_dec", inst_to_dec, 32'h0);
        check32("rst_pc_to_dec",   pc_to_dec,   32'h0);

        // Cold start: four misses, first issue at cycle 6.
        foreach (req_q[i]) req_q.delete(i);
        req_q.push_back(32'h0); req_q.push_back(32'h4);
        req_q.push_back(32'h8); req_q.push_back(32'hC);
        push_issue(32'h0, 32'h00000013);
        push_issue(32'h4, 32'h00000413);
        push_issue(32'h8, 32'h00000813);
        push_issue(32'hC, 32'h00000C13);
        rst = 1'b1; stall_in = 1'b0;
        wait_issue(32'h0, "cold_issue_0", n);
        check32("cold_issue_cycle", 32'(n), 32'd6);
        wait_issue(32'h4, "cold_issue_4", n);
        wait_issue(32'h8, "cold_issue_8", n);
        wait_issue(32'hC, "cold_issue_c", n);

        // Loop refetch from cache: four back-to-back hits.
        jf_stim = 1'b1; jpc_stim = 32'h0;
        push_issue(32'h0, 32'h00000013);
        push_issue(32'h4, 32'h00000413);
        push_issue(32'h8, 32'h00000813);
        push_issue(32'hC, 32'h00000C13);
        @(negedge clk);
        jf_stim = 1'b0;
        check1("jump_cycle_no_issue", flag_to_dec, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("loop_pulse", flag_to_dec, 1'b1);
            check1("loop_no_req", flag_to_mem, 1'b0);
        end

        // Stall for five cycles during hits.
        jf_stim = 1'b1; jpc_stim = 32'h0;
        push_issue(32'h0, 32'h00000013);
        @(negedge clk);
        jf_stim = 1'b0;
        wait_issue(32'h0, "pre_stall_issue", n);
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("stall_no_issue", flag_to_dec, 1'b0);
        end
        push_issue(32'h4, 32'h00000413);
        push_issue(32'h8, 32'h00000813);
        push_issue(32'hC, 32'h00000C13);
        req_q.push_back(32'h10);
        stall_in = 1'b0;
        wait_issue(32'h4, "resume_issue_4", n);
        wait_issue(32'hC, "resume_issue_c", n);

        // Reset during WAIT_MEM, then a stray ack while idle.
        wait_req("req_0x10");
        #1;
        rst = 1'b0; stall_in = 1'b1;
        @(negedge clk);
        check1 ("midreset_flag_to_mem", flag_to_mem, 1'b0);
        check32("midreset_addr_to_mem", addr_to_mem, 32'h0);
        rst = 1'b1;
        stray_cnt++;
        repeat (4) @(negedge clk);
        check1("stray_ack_idle", flag_to_mem, 1'b0);

        // Redirect while waiting on 0x8: line 0x8 still filled, no issue.
        req_q.push_back(32'h8);
        jf_stim = 1'b1; jpc_stim = 32'h8; stall_in = 1'b0;
        @(negedge clk);
        jf_stim = 1'b0;
        wait_req("req_0x8");
        jf_stim = 1'b1; jpc_stim = 32'h100;
        req_q.push_back(32'h100);
        push_issue(32'h100, 32'h00010013);
        @(negedge clk);
        jf_stim = 1'b0;
        wait_issue(32'h100, "issue_0x100", n);
        jf_stim = 1'b1; jpc_stim = 32'h8; stall_in = 1'b1;
        push_issue(32'h8, 32'h00000813);
        @(negedge clk);
        jf_stim = 1'b0; stall_in = 1'b0;
        wait_issue(32'h8, "filled_0x8_hit", n);
        stall_in = 1'b1;

        // Redirect and ack in the same cycle.
        jump_on_ack = 1'b1; jump_on_ack_pc = 32'h200;
        req_q.push_back(32'hC);
        req_q.push_back(32'h200);
        push_issue(32'h200, 32'h00020013);
        stall_in = 1'b0;
        wait_issue(32'h200, "issue_0x200", n);
        jump_on_ack = 1'b0;
        jf_stim = 1'b1; jpc_stim = 32'hC; stall_in = 1'b1;
        push_issue(32'hC, 32'h00000C13);
        @(negedge clk);
        jf_stim = 1'b0; stall_in = 1'b0;
        wait_issue(32'hC, "filled_0xc_hit", n);
        stall_in = 1'b1;

        // Index conflict: 0x0, 0x400, 0x0 all miss.
        req_q.push_back(32'h0);
        push_issue(32'h0, 32'h00000013);
        jf_stim = 1'b1; jpc_stim = 32'h0; stall_in = 1'b0;
        @(negedge clk);
        jf_stim = 1'b0;
        wait_issue(32'h0, "conflict_issue_0a", n);
        req_q.push_back(32'h400);
        push_issue(32'h400, 32'h00040013);
        jf_stim = 1'b1; jpc_stim = 32'h400;
        @(negedge clk);
        jf_stim = 1'b0;
        wait_issue(32'h400, "conflict_issue_400", n);
        req_q.push_back(32'h0);
        push_issue(32'h0, 32'h00000013);
        jf_stim = 1'b1; jpc_stim = 32'h0;
        @(negedge clk);
        jf_stim = 1'b0;
        wait_issue(32'h0, "conflict_issue_0b", n);
        stall_in = 1'b1;

        // rdy low freezes everything, including the issue pulse.
        push_issue(32'h100, 32'h00010013);
        jf_stim = 1'b1; jpc_stim = 32'h100; stall_in = 1'b0;
        @(negedge clk);
        jf_stim = 1'b0;
        wait_issue(32'h100, "rdy_issue_0x100", n);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1 ("rdy_hold_flag", flag_to_dec, 1'b1);
            check32("rdy_hold_pc", pc_to_dec, 32'h100);
            check1 ("rdy_hold_no_req", flag_to_mem, 1'b0);
        end
        req_q.push_back(32'h104);
        push_issue(32'h104, 32'h00010413);
        rdy = 1'b1;
        wait_issue(32'h104, "rdy_resume_0x104", n);
        stall_in = 1'b1;

        repeat (3) @(negedge clk);
        check32("issue_q_drained", 32'(issue_q.size()), 32'd0);
        check32("req_q_drained",   32'(req_q.size()),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
